// File: rtl/chicken_mover.sv
// chicken_mover: moves each player's chicken around the track and pulses next_turn on a mismatch; define TAIL_STEAL_EN to enable tail stealing and winning
module chicken_mover #(
    parameter int TRACK_LEN = 24,
    parameter int POS_W     = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         n_players_i,
    input  logic [1:0]         turn_i,
    input  logic               move_req_i,
    input  logic               match_i,
    output logic               busy_o,
    output logic               next_turn_o,
    output logic [4*POS_W-1:0] pos_flat_o,
    output logic [11:0]        tails_flat_o,
    output logic               winner_valid_o,
    output logic [1:0]         winner_id_o
);
`ifdef TAIL_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, TURN, STEP, CHECK} state_t;
    state_t           state_q, state_d;
    logic [POS_W-1:0] pos_q [4];
    logic [POS_W-1:0] pos_d [4];
    logic [2:0]       tails_q [4];
    logic [2:0]       tails_d [4];
    logic [POS_W-1:0] tgt_q, tgt_d;
    logic [1:0]       cur_q, cur_d;
    logic [2:0]       nact_q, nact_d;
    logic             next_turn_q, next_turn_d;
    logic             winner_valid_q, winner_valid_d;
    logic [1:0]       winner_id_q, winner_id_d;
    logic [2:0]       nact_in;
    logic             accept, occ;
    logic [1:0]       occ_id;

    function automatic logic [POS_W-1:0] wrap_inc(input logic [POS_W-1:0] t);
        return (t == POS_W'(TRACK_LEN - 1)) ? '0 : t + 1'b1;
    endfunction

    assign nact_in = (n_players_i == 2'b00) ? 3'd2 : (n_players_i == 2'b01) ? 3'd3 : 3'd4;
    assign accept  = move_req_i && (state_q == IDLE) && !winner_valid_q && ({1'b0, turn_i} < nact_in);

    // Chickens never share a tile, so at most one active occupant matches
    always_comb begin
        occ    = 1'b0;
        occ_id = '0;
        for (int q = 0; q < 4; q++)
            if (q < int'(nact_q) && 2'(q) != cur_q && pos_q[q] == tgt_q) begin
                occ    = 1'b1;
                occ_id = 2'(q);
            end
    end

    always_comb begin
        state_d        = state_q;
        pos_d          = pos_q;
        tails_d        = tails_q;
        tgt_d          = tgt_q;
        cur_d          = cur_q;
        nact_d         = nact_q;
        next_turn_d    = 1'b0;
        winner_valid_d = winner_valid_q;
        winner_id_d    = winner_id_q;
        case (state_q)
            IDLE: if (accept) begin
                cur_d       = turn_i;
                nact_d      = nact_in;
                next_turn_d = !match_i;
                tgt_d       = wrap_inc(pos_q[turn_i]);
                state_d     = match_i ? STEP : TURN;
            end
            TURN: state_d = IDLE;
            STEP: if (occ) begin
                if (STEAL) begin
                    tails_d[cur_q]  = tails_q[cur_q] + tails_q[occ_id];
                    tails_d[occ_id] = '0;
                end
                tgt_d = wrap_inc(tgt_q);
            end else begin
                pos_d[cur_q] = tgt_q;
                state_d      = CHECK;
            end
            CHECK: begin
                if (STEAL && tails_q[cur_q] == nact_q) begin
                    winner_valid_d = 1'b1;
                    winner_id_d    = cur_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            for (int p = 0; p < 4; p++) begin
                pos_q[p]   <= POS_W'(p * TRACK_LEN / 4);
                tails_q[p] <= 3'd1;
            end
            tgt_q          <= '0;
            cur_q          <= '0;
            nact_q         <= 3'd2;
            next_turn_q    <= 1'b0;
            winner_valid_q <= 1'b0;
            winner_id_q    <= '0;
        end else begin
            state_q        <= state_d;
            pos_q          <= pos_d;
            tails_q        <= tails_d;
            tgt_q          <= tgt_d;
            cur_q          <= cur_d;
            nact_q         <= nact_d;
            next_turn_q    <= next_turn_d;
            winner_valid_q <= winner_valid_d;
            winner_id_q    <= winner_id_d;
        end
    end

    for (genvar p = 0; p < 4; p++) begin : g_flat
        assign pos_flat_o[p*POS_W +: POS_W] = pos_q[p];
        assign tails_flat_o[p*3 +: 3]       = tails_q[p];
    end

    assign busy_o         = (state_q != IDLE);
    assign next_turn_o    = next_turn_q;
    assign winner_valid_o = winner_valid_q;
    assign winner_id_o    = winner_id_q;
endmodule

// File: tb/tb_chicken_mover.sv
// tb_chicken_mover: directed and random moves checked against a tile-by-tile game model
module tb_chicken_mover;
    localparam int L = 24;
    localparam int W = 5;
`ifdef TAIL_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif
    logic           clk = 1'b0, rst = 1'b1;
    logic [1:0]     n_players = '0, turn = '0;
    logic           move_req = 1'b0, match = 1'b0;
    logic           busy, next_turn, winner_valid;
    logic [1:0]     winner_id;
    logic [4*W-1:0] pos_flat;
    logic [11:0]    tails_flat;
    int             checks = 0, errs = 0;
    int             m_pos[4], m_tails[4], m_nact, m_wid;
    bit             m_wv;

    chicken_mover #(.TRACK_LEN(L), .POS_W(W)) dut (
        .clk(clk), .rst(rst), .n_players_i(n_players), .turn_i(turn),
        .move_req_i(move_req), .match_i(match), .busy_o(busy), .next_turn_o(next_turn),
        .pos_flat_o(pos_flat), .tails_flat_o(tails_flat),
        .winner_valid_o(winner_valid), .winner_id_o(winner_id)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int occupant(input int x, input int me);
        for (int q = 0; q < m_nact; q++)
            if (q != me && m_pos[q] == x) return q;
        return -1;
    endfunction

    task automatic model_reset(input logic [1:0] np);
        for (int p = 0; p < 4; p++) begin
            m_pos[p]   = p * L / 4;
            m_tails[p] = 1;
        end
        m_nact = (np == 2'd0) ? 2 : (np == 2'd1) ? 3 : 4;
        m_wv   = 1'b0;
        m_wid  = 0;
    endtask

    task automatic chk_state(input string tag);
        logic [4*W-1:0] ep;
        logic [11:0]    et;
        for (int p = 0; p < 4; p++) begin
            ep[p*W +: W] = W'(m_pos[p]);
            et[p*3 +: 3] = 3'(m_tails[p]);
        end
        chk({tag, " pos_flat"}, 64'(pos_flat), 64'(ep));
        chk({tag, " tails_flat"}, 64'(tails_flat), 64'(et));
        chk({tag, " winner_valid"}, 64'(winner_valid), 64'(m_wv));
        chk({tag, " winner_id"}, 64'(winner_id), 64'(m_wid));
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " next_turn"}, 64'(next_turn), 64'd0);
    endtask

    task automatic do_reset(input logic [1:0] np);
        @(negedge clk);
        rst       = 1'b1;
        n_players = np;
        model_reset(np);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_move(input string tag, input int t, input bit mt);
        int exp_busy = 0, exp_nt = 0, nb = 0, nn = 0, first_nt = 0, x, j = 0, q;
        bit acc = !m_wv && t < m_nact;
        if (acc && !mt) begin
            exp_busy = 1;
            exp_nt   = 1;
        end
        if (acc && mt) begin
            x = (m_pos[t] + 1) % L;
            q = occupant(x, t);
            while (q >= 0) begin
                if (STEAL) begin
                    m_tails[t] += m_tails[q];
                    m_tails[q] = 0;
                end
                x = (x + 1) % L;
                j++;
                q = occupant(x, t);
            end
            m_pos[t] = x;
            exp_busy = 2 + j;
            if (STEAL && m_tails[t] == m_nact) begin
                m_wv  = 1'b1;
                m_wid = t;
            end
        end
        @(negedge clk);
        turn     = 2'(t);
        match    = mt;
        move_req = 1'b1;
        @(negedge clk);
        move_req = 1'b0;
        for (int c = 0; c < 12 && busy === 1'b1; c++) begin
            if (next_turn === 1'b1) begin
                nn++;
                if (c == 0) first_nt = 1;
            end
            nb++;
            move_req = 1'($urandom_range(0, 1));
            turn     = 2'($urandom_range(0, 3));
            match    = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        move_req = 1'b0;
        chk({tag, " busy_cycles"}, 64'(nb), 64'(exp_busy));
        chk({tag, " pulses"}, 64'(nn), 64'(exp_nt));
        if (exp_nt == 1) chk({tag, " pulse_first_cycle"}, 64'(first_nt), 64'd1);
        chk_state(tag);
    endtask

    initial begin
        do_reset(2'd0);
        chk_state("reset");
        do_move("mismatch", 0, 1'b0);
        do_move("step", 0, 1'b1);
        for (int i = 0; i < 4; i++) do_move("advance", 0, 1'b1);
        do_move("jump", 0, 1'b1);
        do_move("after_jump", 1, 1'b1);
        do_reset(2'd0);
        for (int i = 0; i < 17; i++) do_move("to_end", 1, 1'b1);
        do_move("wrap", 1, 1'b1);
        do_reset(2'd0);
        do_move("bad_turn", 3, 1'b1);
        do_move("bad_turn_mis", 2, 1'b0);
        @(negedge clk);
        turn     = 2'd0;
        match    = 1'b1;
        move_req = 1'b1;
        @(negedge clk);
        move_req = 1'b0;
        chk("mid_step busy", 64'(busy), 64'd1);
        #1 rst = 1'b1;
        model_reset(2'd0);
        #1 chk_state("rst_mid_step");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        turn     = 2'd1;
        match    = 1'b0;
        move_req = 1'b1;
        @(negedge clk);
        move_req = 1'b0;
        chk("pending pulse", 64'(next_turn), 64'd1);
        #1 rst = 1'b1;
        #1 chk_state("rst_drops_pulse");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("no pulse after rst", 64'(next_turn), 64'd0);
        for (int r = 0; r < 6; r++) begin
            do_reset(2'($urandom_range(0, 3)));
            for (int k = 0; k < 40; k++)
                do_move("rand", int'($urandom_range(0, 3)), $urandom_range(0, 9) < 7);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
